trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 33 +++
 rtl/trace_fifo.sv | 57 +++++
 rtl/trace_capture.sv | 128 ++++++++++++
 tb/tb_trace_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the CPU trace capture block: record layout, FSM states and
// the record-to-beat mapping used by the serializer.
package trace_pkg;

  localparam int unsigned BEATS_PER_REC = 4;
  localparam int unsigned BEAT_W        = $clog2(BEATS_PER_REC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [15:0] cycle;
    logic        zf;
    logic        of;
  } record_t;

  // Word carried by beat idx of a record.
  function automatic logic [31:0] beat_word(input record_t rec, input logic [BEAT_W-1:0] idx);
    case (idx)
      2'd0:    return {rec.cycle, 14'b0, rec.zf, rec.of};
      2'd1:    return rec.pc;
      2'd2:    return rec.inst;
      default: return rec.result;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock record FIFO. Exposes the head and the entry behind it so the
// serializer can roll straight into the next record on the popping edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  record_t                push_data,
  input  logic                   pop,
  output record_t                head,
  output record_t                next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  record_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign next    = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trace_capture.sv
// Captures retired-instruction records from the CPU into a FIFO and streams
// each one out as four 32-bit beats on a valid/ready interface.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] STOP_PC = 32'h0000_0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arm,
  input  logic        clear,
  input  logic        cap_en,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  input  logic [31:0] cpu_result,
  input  logic        cpu_zf,
  input  logic        cpu_of,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [1:0]  state,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_REC - 1);

  state_t            st;
  logic [15:0]       cycle_cnt;
  record_t           cap_rec;
  record_t           head;
  record_t           next;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              capture;
  logic              push;
  logic              pop;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;

  assign state    = st;
  assign capture  = (st == ST_RUN) && cap_en && !clear;
  assign push     = capture && !full;
  assign beat_nxt = beat + BEAT_W'(1);
  assign pop      = out_valid && out_ready && (beat == LAST_BEAT);
  assign cap_rec  = '{pc: cpu_pc, inst: cpu_inst, result: cpu_result,
                      cycle: cycle_cnt, zf: cpu_zf, of: cpu_of};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cap_rec),
    .pop       (pop),
    .head      (head),
    .next      (next),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Capture FSM; a record is consumed (stored or dropped) on every cap_en in RUN.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      st        <= ST_IDLE;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (arm) begin
            st        <= ST_RUN;
            cycle_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (cap_en) begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (full) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
              overflow <= 1'b1;
            end
            if (cpu_pc == STOP_PC) st <= ST_DONE;
          end
        end
        default: st <= st;
      endcase
    end
  end

  // Serializer reads the FIFO head in place and pops it with the final beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      beat      <= '0;
    end else if (!out_valid) begin
      if (!empty) begin
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        out_data  <= beat_word(head, '0);
        beat      <= '0;
      end
    end else if (out_ready) begin
      if (beat != LAST_BEAT) begin
        beat     <= beat_nxt;
        out_data <= beat_word(head, beat_nxt);
        out_last <= (beat_nxt == LAST_BEAT);
      end else if (count >= CNT_W'(2)) begin
        beat     <= '0;
        out_data <= beat_word(next, '0);
        out_last <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_data  <= '0;
        beat      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: basic record, stop PC, overflow and drop
// saturation, backpressure, clear versus reset, and cycle-field wrap.
module tb_trace_capture;

  logic        clock;
  logic        reset;
  logic        arm;
  logic        clear;
  logic        cap_en;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_inst;
  logic [31:0] cpu_result;
  logic        cpu_zf;
  logic        cpu_of;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  state;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];

  trace_capture #(.DEPTH(16), .STOP_PC(32'h0000_0040)) dut (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .clear      (clear),
    .cap_en     (cap_en),
    .cpu_pc     (cpu_pc),
    .cpu_inst   (cpu_inst),
    .cpu_result (cpu_result),
    .cpu_zf     (cpu_zf),
    .cpu_of     (cpu_of),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .state      (state),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Beats that will be accepted on the coming rising edge.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rec(input logic [15:0] cyc, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] res, input logic zf, input logic of);
    exp_q.push_back({1'b0, cyc, 14'b0, zf, of});
    exp_q.push_back({1'b0, pc});
    exp_q.push_back({1'b0, inst});
    exp_q.push_back({1'b1, res});
  endtask

  task automatic capture(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] res, input logic zf, input logic of);
    cap_en = 1'b1; cpu_pc = pc; cpu_inst = inst; cpu_result = res; cpu_zf = zf; cpu_of = of;
    step(1);
    cap_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; arm = 1'b0; clear = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    step(2);
    reset = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && got_q.size() < exp_q.size(); i++) step(1);
    step(8);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  logic        prev_valid;
  logic        prev_ready;
  logic [31:0] prev_data;
  int          snap;

  initial begin
    reset = 1'b0; arm = 1'b0; clear = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    cpu_pc = '0; cpu_inst = '0; cpu_result = '0; cpu_zf = 1'b0; cpu_of = 1'b0;

    // Reset values
    do_reset();
    check("rst_state", 64'(state), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));

    // Scenario 1: one record, sink always ready
    do_arm();
    check("s1_run", 64'(state), 64'(1));
    out_ready = 1'b1;
    exp_rec(16'h0, 32'h0, 32'h123450B7, 32'h12345000, 1'b0, 1'b0);
    capture(32'h0, 32'h123450B7, 32'h12345000, 1'b0, 1'b0);
    check("s1_noflow", 64'(out_valid), 64'(0));
    step(1);
    check("s1_valid", 64'(out_valid), 64'(1));
    drain(50);
    compare_stream("s1");
    check("s1_idle_valid", 64'(out_valid), 64'(0));

    // Scenario 2: stop PC ends capture; later cap_en ignored
    do_reset();
    do_arm();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_rec(16'(i), 32'(i * 4), 32'h1000 + 32'(i), 32'h2000 + 32'(i), i[0], i[1]);
      capture(32'(i * 4), 32'h1000 + 32'(i), 32'h2000 + 32'(i), i[0], i[1]);
    end
    check("s2_done", 64'(state), 64'(2));
    capture(32'h44, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1);
    check("s2_still_done", 64'(state), 64'(2));
    do_arm();
    check("s2_arm_ignored", 64'(state), 64'(2));
    drain(300);
    check("s2_drop", 64'(drop_cnt), 64'(0));
    compare_stream("s2");

    // Scenario 3: stalled sink, 20 captures, 4 dropped
    do_reset();
    do_arm();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_rec(16'(i), 32'h100 + 32'(i * 4), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
      capture(32'h100 + 32'(i * 4), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
    end
    check("s3_drop", 64'(drop_cnt), 64'(4));
    check("s3_ovf", 64'(overflow), 64'(1));
    check("s3_hold_valid", 64'(out_valid), 64'(1));
    check("s3_hold_data", 64'(out_data), 64'(0));
    out_ready = 1'b1;
    drain(300);
    compare_stream("s3");
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) capture(32'h800 + 32'(i * 4), 32'h0, 32'h0, 1'b0, 1'b0);
    check("s3_drop_sat", 64'(drop_cnt), 64'(255));

    // Scenario 4: ready toggles every cycle
    do_reset();
    do_arm();
    exp_rec(16'h0, 32'h8, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1);
    capture(32'h8, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2) == 1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      step(1);
      if (prev_valid && !prev_ready) begin
        check($sformatf("s4_hold_v%0d", i), 64'(out_valid), 64'(1));
        check($sformatf("s4_hold_d%0d", i), 64'(out_data), 64'(prev_data));
      end
    end
    out_ready = 1'b1;
    drain(50);
    compare_stream("s4");

    // Scenario 5a: clear mid-stream keeps the stream going
    do_reset();
    do_arm();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_rec(16'(i), 32'h100 + 32'(i * 4), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
      capture(32'h100 + 32'(i * 4), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
    end
    check("s5_drop_pre", 64'(drop_cnt), 64'(2));
    out_ready = 1'b1;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("s5_clr_state", 64'(state), 64'(0));
    check("s5_clr_drop", 64'(drop_cnt), 64'(0));
    check("s5_clr_ovf", 64'(overflow), 64'(0));
    capture(32'h44, 32'h1, 32'h2, 1'b0, 1'b0);
    capture(32'h48, 32'h1, 32'h2, 1'b0, 1'b0);
    drain(300);
    compare_stream("s5");

    // Scenario 5b: reset mid-record abandons it
    do_arm();
    capture(32'h20, 32'h77, 32'h88, 1'b0, 1'b0);
    step(2);
    check("s5_pre_valid", 64'(out_valid), 64'(1));
    snap = got_q.size();
    reset = 1'b0;
    step(1);
    check("s5_rst_valid", 64'(out_valid), 64'(0));
    reset = 1'b1;
    step(5);
    check("s5_rst_empty", 64'(out_valid), 64'(0));
    check("s5_rst_state", 64'(state), 64'(0));
    check("s5_rst_beats", 64'(got_q.size()), 64'(snap));

    // Scenario 6: cycle field wraps after 0xFFFF
    do_reset();
    do_arm();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) capture(32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
    step(100);
    got_q.delete();
    exp_q.delete();
    exp_rec(16'hFFFF, 32'h300, 32'h11, 32'h22, 1'b0, 1'b1);
    exp_rec(16'h0000, 32'h304, 32'h33, 32'h44, 1'b1, 1'b0);
    capture(32'h300, 32'h11, 32'h22, 1'b0, 1'b1);
    capture(32'h304, 32'h33, 32'h44, 1'b1, 1'b0);
    drain(100);
    compare_stream("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
